// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack for the frontend branch predictor
//
// Ports:
//   clk_i        core clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   flush_bp_i   clears the whole stack, wins over push/pop
//   push_i       push data_i as the new top (predicted call)
//   pop_i        discard the current top (predicted return)
//   data_i       return address to push
//   top_valid_o  top entry holds a valid address
//   top_addr_o   top entry address, zero when top_valid_o is low
//   depth_o      number of valid entries
//   overflow_o   one-cycle pulse after a push overwrote the oldest entry
//   underflow_o  one-cycle pulse after a pop on an empty stack
package config_pkg;
    typedef struct packed {
        int unsigned RASDepth;
        int unsigned VLEN;
    } cva6_cfg_t;
endpackage

module ras_stack #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_t'(0),
    // an all-zero configuration falls back to the smallest legal stack
    localparam int unsigned Depth = (CVA6Cfg.RASDepth < 2) ? 2 : CVA6Cfg.RASDepth,
    localparam int unsigned Vlen  = (CVA6Cfg.VLEN < 1) ? 1 : CVA6Cfg.VLEN,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [Vlen-1:0] data_i,
    output logic            top_valid_o,
    output logic [Vlen-1:0] top_addr_o,
    output logic [CntW-1:0] depth_o,
    output logic            overflow_o,
    output logic            underflow_o
);
    logic [Depth-1:0] r_valid;
    logic [Vlen-1:0]  r_addr [Depth];
    logic [PtrW-1:0]  r_tp;
    logic [CntW-1:0]  r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic [PtrW-1:0]  w_tp_inc;
    logic [PtrW-1:0]  w_tp_dec;
    logic             w_full;
    logic             w_empty;

    // explicit wrap so non-power-of-two depths stay in range
    always_comb begin
        w_tp_inc = (r_tp == PtrW'(Depth - 1)) ? '0 : r_tp + PtrW'(1);
        w_tp_dec = (r_tp == '0) ? PtrW'(Depth - 1) : r_tp - PtrW'(1);
        w_full   = r_cnt == CntW'(Depth);
        w_empty  = r_cnt == '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_addr  <= '{default: '0};
            r_tp    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            if (flush_bp_i) begin
                r_valid <= '0;
                r_tp    <= '0;
                r_cnt   <= '0;
            end else if (push_i && pop_i) begin
                // tail call: replace the top in place
                r_valid[r_tp] <= 1'b1;
                r_addr[r_tp]  <= data_i;
                if (w_empty) r_cnt <= CntW'(1);
            end else if (push_i) begin
                // when full the slot after the top is the oldest entry
                r_tp              <= w_tp_inc;
                r_valid[w_tp_inc] <= 1'b1;
                r_addr[w_tp_inc]  <= data_i;
                if (w_full) r_ovf <= 1'b1;
                else        r_cnt <= r_cnt + CntW'(1);
            end else if (pop_i) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_valid[r_tp] <= 1'b0;
                    r_tp          <= w_tp_dec;
                    r_cnt         <= r_cnt - CntW'(1);
                end
            end
        end
    end

    assign top_valid_o = r_valid[r_tp];
    assign top_addr_o  = top_valid_o ? r_addr[r_tp] : '0;
    assign depth_o     = r_cnt;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;
endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: directed scoreboard bench for ras_stack at depths 4 and 3
module tb_ras_stack;
    localparam config_pkg::cva6_cfg_t Cfg4 = '{RASDepth: 4, VLEN: 39};
    localparam config_pkg::cva6_cfg_t Cfg3 = '{RASDepth: 3, VLEN: 39};

    typedef struct {
        string      name;
        int         cyc;
        bit         sel;
        logic [44:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl4 = 1'b0, pu4 = 1'b0, po4 = 1'b0;
    logic        fl3 = 1'b0, pu3 = 1'b0, po3 = 1'b0;
    logic [38:0] d4 = '0, d3 = '0;
    logic        tv4, ov4, un4, tv3, ov3, un3;
    logic [38:0] ta4, ta3;
    logic [2:0]  dp4;
    logic [1:0]  dp3;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q[$];

    ras_stack #(.CVA6Cfg(Cfg4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_bp_i(fl4), .push_i(pu4), .pop_i(po4),
        .data_i(d4), .top_valid_o(tv4), .top_addr_o(ta4), .depth_o(dp4),
        .overflow_o(ov4), .underflow_o(un4)
    );

    ras_stack #(.CVA6Cfg(Cfg3)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_bp_i(fl3), .push_i(pu3), .pop_i(po3),
        .data_i(d3), .top_valid_o(tv3), .top_addr_o(ta3), .depth_o(dp3),
        .overflow_o(ov3), .underflow_o(un3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            logic [44:0] a;
            e = q.pop_front();
            a = e.sel ? {tv3, ta3, 1'b0, dp3, ov3, un3} : {tv4, ta4, dp4, ov4, un4};
            n_total++;
            if (a === e.v) n_pass++;
            else $display("FAIL %s: got tv=%0b addr=%h depth=%0d ovf=%0b unf=%0b, want tv=%0b addr=%h depth=%0d ovf=%0b unf=%0b",
                e.name, a[44], a[43:5], a[4:2], a[1], a[0], e.v[44], e.v[43:5], e.v[4:2], e.v[1], e.v[0]);
        end
    end

    task automatic op(input bit sel, input bit r, input bit f, input bit pu, input bit po,
                      input logic [38:0] d, input string nm, input bit etv,
                      input logic [38:0] eta, input logic [2:0] edp, input bit eov, input bit eun);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {fl4, pu4, po4, d4} = sel ? '0 : {f, pu, po, d};
        {fl3, pu3, po3, d3} = sel ? {f, pu, po, d} : '0;
        e.name = nm;
        e.cyc  = cyc + 1;
        e.sel  = sel;
        e.v    = {etv, eta, edp, eov, eun};
        q.push_back(e);
    endtask

    initial begin
        op(0, 1, 0, 0, 0, 0,       "rst4",        0, 0,       0, 0, 0);
        op(1, 1, 0, 0, 0, 0,       "rst3",        0, 0,       0, 0, 0);
        op(0, 0, 0, 0, 0, 0,       "idle_after",  0, 0,       0, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "empty_pop",   0, 0,       0, 0, 1);
        op(0, 0, 0, 0, 0, 0,       "unf_clear",   0, 0,       0, 0, 0);
        op(0, 0, 0, 1, 0, 'h100,   "lifo_push1",  1, 'h100,   1, 0, 0);
        op(0, 0, 0, 1, 0, 'h200,   "lifo_push2",  1, 'h200,   2, 0, 0);
        op(0, 0, 0, 1, 0, 'h300,   "lifo_push3",  1, 'h300,   3, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "lifo_pop1",   1, 'h200,   2, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "lifo_pop2",   1, 'h100,   1, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "lifo_pop3",   0, 0,       0, 0, 0);
        op(0, 0, 0, 1, 0, 'h10,    "ovf_push1",   1, 'h10,    1, 0, 0);
        op(0, 0, 0, 1, 0, 'h20,    "ovf_push2",   1, 'h20,    2, 0, 0);
        op(0, 0, 0, 1, 0, 'h30,    "ovf_push3",   1, 'h30,    3, 0, 0);
        op(0, 0, 0, 1, 0, 'h40,    "ovf_push4",   1, 'h40,    4, 0, 0);
        op(0, 0, 0, 1, 0, 'h50,    "ovf_push5",   1, 'h50,    4, 1, 0);
        op(0, 0, 0, 0, 0, 0,       "ovf_clear",   1, 'h50,    4, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "ovf_pop1",    1, 'h40,    3, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "ovf_pop2",    1, 'h30,    2, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "ovf_pop3",    1, 'h20,    1, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "ovf_pop4",    0, 0,       0, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "ovf_pop5",    0, 0,       0, 0, 1);
        op(0, 0, 0, 1, 0, 'h100,   "tc_push1",    1, 'h100,   1, 0, 0);
        op(0, 0, 0, 1, 0, 'h200,   "tc_push2",    1, 'h200,   2, 0, 0);
        op(0, 0, 0, 1, 1, 'h999,   "tc_pushpop",  1, 'h999,   2, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "tc_pop1",     1, 'h100,   1, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "tc_pop2",     0, 0,       0, 0, 0);
        op(0, 0, 0, 1, 1, 'hAA,    "tc_empty",    1, 'hAA,    1, 0, 0);
        op(0, 0, 0, 0, 1, 0,       "tc_empty_pop",0, 0,       0, 0, 0);
        op(0, 0, 0, 1, 0, 'h11,    "fl_push1",    1, 'h11,    1, 0, 0);
        op(0, 0, 0, 1, 0, 'h22,    "fl_push2",    1, 'h22,    2, 0, 0);
        op(0, 0, 0, 1, 0, 'h33,    "fl_push3",    1, 'h33,    3, 0, 0);
        op(0, 0, 1, 1, 1, 'h77,    "fl_all",      0, 0,       0, 0, 0);
        op(0, 0, 0, 1, 0, 'h88,    "fl_after",    1, 'h88,    1, 0, 0);
        op(0, 0, 0, 1, 0, 'h99,    "rst_pre",     1, 'h99,    2, 0, 0);
        op(0, 1, 0, 1, 0, 'h55,    "rst_mid",     0, 0,       0, 0, 0);
        op(0, 0, 0, 0, 0, 0,       "rst_hold",    0, 0,       0, 0, 0);
        op(1, 0, 0, 1, 0, 'h101,   "d3_push1",    1, 'h101,   1, 0, 0);
        op(1, 0, 0, 1, 0, 'h102,   "d3_push2",    1, 'h102,   2, 0, 0);
        op(1, 0, 0, 1, 0, 'h103,   "d3_push3",    1, 'h103,   3, 0, 0);
        op(1, 0, 0, 1, 0, 'h104,   "d3_push4",    1, 'h104,   3, 1, 0);
        op(1, 0, 0, 1, 0, 'h105,   "d3_push5",    1, 'h105,   3, 1, 0);
        op(1, 0, 0, 1, 0, 'h106,   "d3_push6",    1, 'h106,   3, 1, 0);
        op(1, 0, 0, 1, 0, 'h107,   "d3_push7",    1, 'h107,   3, 1, 0);
        op(1, 0, 0, 0, 1, 0,       "d3_pop1",     1, 'h106,   2, 0, 0);
        op(1, 0, 0, 0, 1, 0,       "d3_pop2",     1, 'h105,   1, 0, 0);
        op(1, 0, 0, 0, 1, 0,       "d3_pop3",     0, 0,       0, 0, 0);
        op(1, 0, 0, 0, 1, 0,       "d3_pop4",     0, 0,       0, 0, 1);
        op(1, 0, 0, 0, 0, 0,       "d3_idle",     0, 0,       0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
